shift_issue_stage: RTL and testbench

SHIFT_ISSUE_STAGE -- requirements
Module: shift_issue_stage

---
 rtl/shift_issue_stage.sv | 128 ++++++++++++
 tb/tb_shift_issue_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_issue_stage.sv
// shift_issue_stage: issue stage between decode and an external arithmetic
// shifter. It accepts one shift request at a time and drives the registered
// operand and shift amount to the shifter. It captures the shifter's
// combinational result one cycle later and holds it for writeback until that
// result is consumed.
//
// A shift amount of zero skips the shifter: the operand becomes the result
// directly, and sh_in/sh_shamt keep their previous values.
//
// A new request may be accepted in the same cycle that writeback consumes the
// current result, so the stage runs without an idle bubble.
//
// Build option: define SHAMT_CLAMP_EN to saturate shift amounts above
// WIDTH-1 to WIDTH-1 when the request is registered.

`default_nettype none

module shift_issue_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    // decode-side request channel
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic [4:0]       req_shamt,

    // arithmetic shifter interface
    output logic [WIDTH-1:0] sh_in,
    output logic [4:0]       sh_shamt,
    input  logic [WIDTH-1:0] sh_out,

    // writeback-side response channel
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,

    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t         state;
    logic           accept;
    logic [4:0]     shamt_eff;

`ifdef SHAMT_CLAMP_EN
    // Largest shift amount that still moves real data bits; for WIDTH > 32
    // the 5-bit field can never exceed it, so no clamping ever happens.
    localparam int         MAX_SHAMT   = (WIDTH - 1 > 31) ? 31 : WIDTH - 1;
    localparam logic [4:0] SHAMT_LIMIT = 5'(MAX_SHAMT);

    // Saturate the requested shift amount to the operand width
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first so
        // no path leaves it unassigned, which would otherwise infer a latch.
        shamt_eff = req_shamt;
        if (req_shamt > SHAMT_LIMIT) begin
            shamt_eff = SHAMT_LIMIT;
        end
    end
`else
    assign shamt_eff = req_shamt;
`endif

    // Handshake and status decode.
    // req_ready follows rsp_ready combinationally in HOLD, so a new request
    // can be accepted in the cycle the held result is consumed.
    assign req_ready = (state == IDLE) || ((state == HOLD) && rsp_ready);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == HOLD);
    assign busy      = (state != IDLE);

    // Control FSM with operand, shift amount and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register here is a small control or data flop with a
        // defined reset value. Reset also drops any in-flight request, so no
        // response can appear after reset.
        if (!rst_n) begin
            state    <= IDLE;
            sh_in    <= '0;
            sh_shamt <= '0;
            rsp_data <= '0;
        end else if (accept) begin
            // A request is accepted in IDLE or on the consuming edge of HOLD.
            // The zero-shift test uses the raw amount: clamping never turns a
            // nonzero amount into zero.
            // NOTE: sequential state uses non-blocking assignments, so every
            // register here samples pre-edge values and the update order
            // inside the block does not matter.
            if (req_shamt != 5'd0) begin
                sh_in    <= req_data;
                sh_shamt <= shamt_eff;
                state    <= ISSUE;
            end else begin
                rsp_data <= req_data;
                state    <= HOLD;
            end
        end else begin
            case (state)
                ISSUE: begin
                    rsp_data <= sh_out;
                    state    <= HOLD;
                end
                HOLD: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_shift_issue_stage.sv
// tb_shift_issue_stage: directed and randomized checks for shift_issue_stage.
// The bench models the external arithmetic shifter as a continuous
// arithmetic right shift. It predicts every response from the requests it
// accepts, using a queue and a bit-level reference function.
// Define SHAMT_CLAMP_EN here too when building the RTL with that option.

`timescale 1ns/1ps

module tb_shift_issue_stage;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_data;
    logic [4:0]   req_shamt;
    logic [W-1:0] sh_in;
    logic [4:0]   sh_shamt;
    logic [W-1:0] sh_out;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic         busy;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_q[$];

    shift_issue_stage #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_shamt (req_shamt),
        .sh_in     (sh_in),
        .sh_shamt  (sh_shamt),
        .sh_out    (sh_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    // External arithmetic shifter: sign-filling right shift
    assign sh_out = W'($signed(sh_in) >>> sh_shamt);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected result: operand shifted right by the effective amount, with
    // vacated bits filled from the sign bit
    function automatic logic [W-1:0] ref_result(input logic [W-1:0] d, input logic [4:0] s);
        logic [W-1:0] r;
        int n;
        n = int'(s);
`ifdef SHAMT_CLAMP_EN
        if (n > W - 1) n = W - 1;
`endif
        if (n == 0) return d;
        for (int i = 0; i < W; i++) begin
            r[i] = (i + n < W) ? d[i + n] : d[W-1];
        end
        return r;
    endfunction

    // Advance one clock; inputs are changed 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboarded cycle: sample handshakes at the falling edge, then clock
    task automatic cycle();
        @(negedge clk);
        if (rsp_valid) begin
            if (exp_q.size() != 0) begin
                check("rsp_data_vs_model", rsp_data, exp_q[0]);
                if (rsp_ready) void'(exp_q.pop_front());
            end else begin
                check("no_spurious_rsp", rsp_valid, 1'b0);
            end
        end
        if (req_valid && req_ready) begin
            exp_q.push_back(ref_result(req_data, req_shamt));
        end
        tick();
    endtask

    initial begin
        logic [4:0] exp_clamp;
`ifdef SHAMT_CLAMP_EN
        exp_clamp = 5'd15;
`else
        exp_clamp = 5'd20;
`endif
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_data  = '0;
        req_shamt = '0;
        rsp_ready = 1'b0;

        // Reset state: checked before the first clock edge
        #3;
        check("rst_sh_in", sh_in, 0);
        check("rst_sh_shamt", sh_shamt, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_req_ready", req_ready, 1);

        // 17 >>> 3 = 2, result two cycles after the transfer
        req_valid = 1'b1; req_data = 16'd17; req_shamt = 5'd3; rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        check("t31_sh_in", sh_in, 17);
        check("t31_sh_shamt", sh_shamt, 3);
        check("t31_issue_rsp_valid", rsp_valid, 0);
        check("t31_issue_req_ready", req_ready, 0);
        check("t31_issue_busy", busy, 1);
        tick();
        check("t31_rsp_valid", rsp_valid, 1);
        check("t31_rsp_data", rsp_data, 16'h0002);
        tick();
        check("t31_idle_rsp_valid", rsp_valid, 0);
        check("t31_idle_busy", busy, 0);

        // 0x8000 >>> 4 = 0xF800, held while writeback stalls
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_data = 16'h8000; req_shamt = 5'd4;
        tick();
        req_data = 16'h5555; req_shamt = 5'd1;
        tick();
        check("t32_rsp_valid", rsp_valid, 1);
        check("t32_rsp_data", rsp_data, 16'hF800);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t32_hold_valid", rsp_valid, 1);
            check("t32_hold_data", rsp_data, 16'hF800);
            check("t32_hold_req_ready", req_ready, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("t32_release_idle", busy, 0);

        // Zero shift bypasses the shifter and leaves its inputs alone
        req_valid = 1'b1; req_data = 16'h1234; req_shamt = 5'd0;
        tick();
        req_valid = 1'b0;
        check("t33_rsp_valid", rsp_valid, 1);
        check("t33_rsp_data", rsp_data, 16'h1234);
        check("t33_sh_in_kept", sh_in, 16'h8000);
        check("t33_sh_shamt_kept", sh_shamt, 4);
        tick();
        check("t33_idle", busy, 0);

        // Oversized shift amount: clamped or passed through depending on build
        req_valid = 1'b1; req_data = 16'h8001; req_shamt = 5'd20;
        tick();
        req_valid = 1'b0;
        check("t34_sh_shamt", sh_shamt, exp_clamp);
        tick();
        check("t34_rsp_data", rsp_data, 16'hFFFF);
        tick();

        // Back-to-back: second request accepted on the HOLD edge
        req_valid = 1'b1; req_data = 16'd17; req_shamt = 5'd3;
        tick();
        req_data = 16'd64; req_shamt = 5'd2;
        check("t35_issue_blocks", req_ready, 0);
        tick();
        check("t35_first_valid", rsp_valid, 1);
        check("t35_first_data", rsp_data, 2);
        check("t35_hold_accepts", req_ready, 1);
        tick();
        req_valid = 1'b0;
        check("t35_second_sh_in", sh_in, 64);
        check("t35_second_sh_shamt", sh_shamt, 2);
        check("t35_second_issue", rsp_valid, 0);
        tick();
        check("t35_second_valid", rsp_valid, 1);
        check("t35_second_data", rsp_data, 16);
        tick();
        check("t35_idle", busy, 0);

        // Reset during ISSUE discards the request
        req_valid = 1'b1; req_data = 16'h00F0; req_shamt = 5'd2;
        tick();
        req_valid = 1'b0;
        check("t36_in_issue", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t36_rst_busy", busy, 0);
        check("t36_rst_rsp_valid", rsp_valid, 0);
        check("t36_rst_sh_in", sh_in, 0);
        check("t36_rst_sh_shamt", sh_shamt, 0);
        check("t36_rst_rsp_data", rsp_data, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t36_no_rsp_after_rst", rsp_valid, 0);
        end

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            int sel;
            req_valid = ($urandom_range(0, 99) < 60);
            rsp_ready = ($urandom_range(0, 99) < 65);
            req_data  = W'($urandom);
            sel       = int'($urandom_range(0, 3));
            if (sel == 0)      req_shamt = 5'd0;
            else if (sel == 1) req_shamt = 5'($urandom_range(16, 31));
            else               req_shamt = 5'($urandom_range(1, 15));
            cycle();
        end

        // Drain: every accepted request must produce exactly one response
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            cycle();
        end
        check("drain_queue_empty", exp_q.size(), 0);
        cycle();
        check("drain_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
